// File: rtl/fifo_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_spi_tx
//  Brief    : FIFO read-side consumer. Pops one word per frame and shifts it
//             out MSB-first on an SPI mode-0 link. Chip select is held across
//             back-to-back frames and released after an idle hold window.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_spi_tx #(
    parameter int DATABITS = 8,   // FIFO word width and SPI frame length
    parameter int CLKDIV   = 2,   // SCK half-period in clk cycles (>=1)
    parameter int CS_HOLD  = 4    // clk cycles CS stays low once FIFO drains (>=1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_fifo_empty,
    input  logic [DATABITS-1:0] i_fifo_read_data,
    output logic                o_fifo_read_en,
    output logic                o_spi_sck,
    output logic                o_spi_mosi,
    output logic                o_spi_cs_n,
    output logic                o_busy,
    output logic                o_byte_done
);

    // Counter widths; kept at least one bit so degenerate parameters still elaborate
    localparam int c_DIV_W  = (CLKDIV   > 1) ? $clog2(CLKDIV)   : 1;
    localparam int c_BIT_W  = (DATABITS > 1) ? $clog2(DATABITS) : 1;
    localparam int c_HOLD_W = (CS_HOLD  > 1) ? $clog2(CS_HOLD)  : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLKDIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATABITS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_read_en;
    logic                  r_sck;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_byte_done;
    logic [DATABITS-1:0]   r_shreg;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic [c_DIV_W-1:0]    r_divcnt;
    logic [c_HOLD_W-1:0]   r_holdcnt;

    // Shift register advanced by one bit; its MSB becomes the next MOSI bit
    logic [DATABITS-1:0]   w_shifted;
    assign w_shifted = r_shreg << 1;

    // Frame sequencer: every output is a flop, MOSI is the shift-register MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_read_en   <= 1'b0;
            r_sck       <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_divcnt    <= '0;
            r_holdcnt   <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse
            r_read_en   <= 1'b0;
            r_byte_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cs_n <= 1'b1;
                    r_sck  <= 1'b0;
                    if (!i_fifo_empty) begin
                        r_state   <= S_FETCH;
                        r_read_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                // Pop strobe is high during this state; data arrives next cycle
                S_FETCH: begin
                    r_cs_n  <= 1'b0;
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_shreg  <= i_fifo_read_data;
                    r_bitcnt <= c_BIT_LAST;
                    r_divcnt <= '0;
                    r_state  <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_divcnt == c_DIV_LAST) begin
                        r_divcnt <= '0;
                        r_sck    <= ~r_sck;
                        // Falling SCK edge: advance data or close the frame
                        if (r_sck) begin
                            if (r_bitcnt == '0) begin
                                r_byte_done <= 1'b1;
                                if (!i_fifo_empty) begin
                                    r_state   <= S_FETCH;
                                    r_read_en <= 1'b1;
                                end else begin
                                    r_state   <= S_HOLD;
                                    r_holdcnt <= '0;
                                end
                            end else begin
                                r_shreg  <= w_shifted;
                                r_bitcnt <= r_bitcnt - 1'b1;
                            end
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 1'b1;
                    end
                end

                // Keep CS low briefly so a late word joins the same CS burst
                S_HOLD: begin
                    r_sck <= 1'b0;
                    if (!i_fifo_empty) begin
                        r_state   <= S_FETCH;
                        r_read_en <= 1'b1;
                    end else if (r_holdcnt == c_HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_holdcnt <= r_holdcnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sck   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_read_en = r_read_en;
    assign o_spi_sck      = r_sck;
    assign o_spi_mosi     = r_shreg[DATABITS-1];
    assign o_spi_cs_n     = r_cs_n;
    assign o_busy         = r_busy;
    assign o_byte_done    = r_byte_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_spi_tx
//  Brief    : Directed bench for fifo_spi_tx with a small FIFO model and an
//             SPI receiver that captures MOSI on every SCK rise.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_spi_tx;

    localparam int DATABITS = 8;
    localparam int CLKDIV   = 2;
    localparam int CS_HOLD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // FIFO model: written by the stimulus, popped on the read strobe
    logic [7:0] mem [0:15];
    logic [4:0] wr_ptr  = '0;
    logic [4:0] rd_ptr  = '0;
    logic [7:0] rd_data = '0;
    logic       fifo_empty;
    assign fifo_empty = (wr_ptr == rd_ptr);

    logic read_en, sck, mosi, cs_n, busy, byte_done;

    fifo_spi_tx #(
        .DATABITS (DATABITS),
        .CLKDIV   (CLKDIV),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_fifo_empty     (fifo_empty),
        .i_fifo_read_data (rd_data),
        .o_fifo_read_en   (read_en),
        .o_spi_sck        (sck),
        .o_spi_mosi       (mosi),
        .o_spi_cs_n       (cs_n),
        .o_busy           (busy),
        .o_byte_done      (byte_done)
    );

    // Read port: data is valid the cycle after the pop strobe
    always @(posedge clk) begin
        if (read_en && !fifo_empty) begin
            rd_data <= mem[rd_ptr[3:0]];
            rd_ptr  <= rd_ptr + 5'd1;
        end
    end

    // Observed activity, accumulated by the monitor
    int         cyc = 0;
    int         re_cnt = 0, bd_cnt = 0, rise_cnt = 0, cs_rise_cnt = 0, cs_low_cnt = 0;
    int         underflow = 0;
    int         last_bd_cyc = 0, cs_rise_cyc = 0, fall_cyc = 0;
    int         nbits = 0, rx_n = 0, gap_n = 0;
    logic [7:0] bits = '0;
    logic [7:0] rx [0:63];
    int         gaps [0:15];
    logic       prev_sck = 1'b0, prev_cs = 1'b1, have_fall = 1'b0;

    // Monitor samples on the falling clk edge, away from DUT updates
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                nbits     = 0;
                have_fall = 1'b0;
            end else begin
                if (read_en) begin
                    re_cnt++;
                    if (fifo_empty) underflow++;
                end
                if (byte_done) begin
                    bd_cnt++;
                    last_bd_cyc = cyc;
                end
                if (!cs_n) cs_low_cnt++;
                if (cs_n && !prev_cs) begin
                    cs_rise_cnt++;
                    cs_rise_cyc = cyc;
                    have_fall   = 1'b0;
                end
                if (sck && !prev_sck) begin
                    rise_cnt++;
                    if (nbits == 0 && have_fall && gap_n < 16) begin
                        gaps[gap_n] = cyc - fall_cyc;
                        gap_n++;
                    end
                    bits = {bits[6:0], mosi};
                    nbits++;
                    if (nbits == 8) begin
                        if (rx_n < 64) rx[rx_n] = bits;
                        rx_n++;
                        nbits = 0;
                    end
                end
                if (!sck && prev_sck) begin
                    fall_cyc  = cyc;
                    have_fall = 1'b1;
                end
            end
            prev_sck = sck;
            prev_cs  = cs_n;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_bd(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (bd_cnt < target && t < budget) begin
            tick(1);
            t++;
        end
        check(name, (bd_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t;
        t = 0;
        while ((busy || !cs_n) && t < budget) begin
            tick(1);
            t++;
        end
        check(name, (!busy && cs_n), 1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_bits;   // MOSI captured on rises 1..8, first bit in [7]
        int         exp_rises;
        int         exp_cs_low; // LOAD + 32 SHIFT + 4 HOLD cycles
        int         exp_cs_dly; // byte_done to cs_n high
    } vec_t;

    vec_t vecs [5];

    initial begin : main
        int re0, bd0, rise0, rx0, csr0, csl0, gap0;

        vecs[0] = '{8'h07, 8'b0000_0111, 8, 37, 4};
        vecs[1] = '{8'h80, 8'b1000_0000, 8, 37, 4};
        vecs[2] = '{8'hFF, 8'b1111_1111, 8, 37, 4};
        vecs[3] = '{8'h00, 8'b0000_0000, 8, 37, 4};
        vecs[4] = '{8'h5A, 8'b0101_1010, 8, 37, 4};

        // Reset state: {read_en,sck,mosi,cs_n,busy,byte_done}
        tick(3);
        check("reset_outputs", {read_en, sck, mosi, cs_n, busy, byte_done}, 6'b000100);
        rst = 1'b0;

        // Empty FIFO for 200 cycles: nothing moves
        re0 = re_cnt; rise0 = rise_cnt; csl0 = cs_low_cnt;
        tick(200);
        check("idle_no_pop",  re_cnt - re0, 0);
        check("idle_no_sck",  rise_cnt - rise0, 0);
        check("idle_cs_high", cs_low_cnt - csl0, 0);
        check("idle_busy",    busy, 0);

        // Single-byte frames from the table
        for (int i = 0; i < 5; i++) begin
            re0 = re_cnt; bd0 = bd_cnt; rise0 = rise_cnt; rx0 = rx_n; csl0 = cs_low_cnt;
            push(vecs[i].din);
            wait_bd(bd0 + 1, 200, "single_done_seen");
            wait_idle(50, "single_idle_seen");
            tick(5);
            check("single_rx_count", rx_n - rx0, 1);
            check("single_rx_bits",  rx[rx0], vecs[i].exp_bits);
            check("single_pops",     re_cnt - re0, 1);
            check("single_done",     bd_cnt - bd0, 1);
            check("single_rises",    rise_cnt - rise0, vecs[i].exp_rises);
            check("single_cs_low",   cs_low_cnt - csl0, vecs[i].exp_cs_low);
            check("single_cs_delay", cs_rise_cyc - last_bd_cyc, vecs[i].exp_cs_dly);
        end

        // Back-to-back burst: CS stays low, 4-cycle fall-to-rise gaps
        re0 = re_cnt; bd0 = bd_cnt; rx0 = rx_n; csr0 = cs_rise_cnt; csl0 = cs_low_cnt; gap0 = gap_n;
        push(8'hFA); push(8'h1B); push(8'hA5);
        wait_bd(bd0 + 3, 600, "burst_done_seen");
        wait_idle(50, "burst_idle_seen");
        tick(5);
        check("burst_rx_count", rx_n - rx0, 3);
        check("burst_rx0", rx[rx0],     8'b1111_1010);
        check("burst_rx1", rx[rx0 + 1], 8'b0001_1011);
        check("burst_rx2", rx[rx0 + 2], 8'b1010_0101);
        check("burst_pops", re_cnt - re0, 3);
        check("burst_done", bd_cnt - bd0, 3);
        check("burst_cs_rises", cs_rise_cnt - csr0, 1);
        check("burst_cs_low", cs_low_cnt - csl0, 105);
        check("burst_gap_count", gap_n - gap0, 2);
        check("burst_gap0", gaps[gap0],     4);
        check("burst_gap1", gaps[gap0 + 1], 4);

        // Late push during the CS hold window joins the same CS burst
        re0 = re_cnt; bd0 = bd_cnt; rx0 = rx_n; csr0 = cs_rise_cnt;
        push(8'h81);
        wait_bd(bd0 + 1, 200, "hold_first_done");
        tick(2);
        push(8'h3C);
        wait_bd(bd0 + 2, 200, "hold_second_done");
        wait_idle(50, "hold_idle_seen");
        tick(5);
        check("hold_rx_count", rx_n - rx0, 2);
        check("hold_rx0", rx[rx0],     8'h81);
        check("hold_rx1", rx[rx0 + 1], 8'h3C);
        check("hold_pops", re_cnt - re0, 2);
        check("hold_cs_rises", cs_rise_cnt - csr0, 1);

        // Reset at the 4th SCK rise of 0x55, then send 0x99
        re0 = re_cnt; rx0 = rx_n;
        rise0 = rise_cnt;
        push(8'h55);
        begin
            int t;
            t = 0;
            while (rise_cnt < rise0 + 4 && t < 200) begin
                tick(1);
                t++;
            end
            check("abort_rise4_seen", (rise_cnt >= rise0 + 4), 1);
        end
        rst = 1'b1;
        #1;
        check("abort_async_outputs", {read_en, sck, mosi, cs_n, busy, byte_done}, 6'b000100);
        rise0 = rise_cnt;
        tick(2);
        check("abort_held_outputs", {read_en, sck, mosi, cs_n, busy, byte_done}, 6'b000100);
        rst = 1'b0;
        tick(10);
        check("abort_no_sck", rise_cnt - rise0, 0);
        check("abort_fifo_empty", fifo_empty, 1);
        check("abort_one_pop", re_cnt - re0, 1);
        check("abort_busy_low", busy, 0);
        bd0 = bd_cnt;
        push(8'h99);
        wait_bd(bd0 + 1, 200, "abort_next_done");
        wait_idle(50, "abort_idle_seen");
        tick(5);
        check("abort_rx_count", rx_n - rx0, 1);
        check("abort_rx_byte", rx[rx0], 8'h99);
        check("abort_total_pops", re_cnt - re0, 2);
        check("abort_fifo_drained", fifo_empty, 1);
        check("no_underflow", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
